// File: rtl/bandit_environment.sv
// Multi-armed bandit environment: each accepted arm index draws a 16-bit Galois LFSR
// sample against that arm's programmed hit threshold and answers with a fixed reward.
module bandit_environment #(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter logic [15:0] REWARD_HIT  = 16'h0100,
    parameter logic [15:0] REWARD_MISS = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        action_valid_i,
    input  logic [7:0]  action_data_i,
    output logic        action_ready_o,
    output logic        reward_valid_o,
    output logic [15:0] reward_data_o,
    input  logic        reward_ready_i,
    input  logic        prob_write_i,
    input  logic [7:0]  prob_addr_i,
    input  logic [15:0] prob_data_i,
    output logic [31:0] pull_count_o,
    output logic [31:0] hit_count_o
);

    typedef enum logic [1:0] {IDLE, LOOKUP, DRAW, RESPOND} state_e;

    state_e      state_q, state_d;
    logic [7:0]  arm_q, arm_d;
    logic [15:0] thresh_q, thresh_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] reward_q, reward_d;
    logic [31:0] pull_q, pull_d;
    logic [31:0] hit_q, hit_d;
    logic        hit;

    logic [15:0] prob_mem [256];

    // Table is never reset; a write in the LOOKUP cycle leaves thresh_q with the old word.
    always_ff @(posedge clk_i) begin
        if (prob_write_i) begin
            prob_mem[prob_addr_i] <= prob_data_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        arm_d    = arm_q;
        thresh_d = thresh_q;
        lfsr_d   = lfsr_q;
        reward_d = reward_q;
        pull_d   = pull_q;
        hit_d    = hit_q;
        hit      = (lfsr_q < thresh_q);
        case (state_q)
            IDLE: begin
                if (action_valid_i) begin
                    state_d = LOOKUP;
                    arm_d   = action_data_i;
                    pull_d  = pull_q + 32'd1;
                end
            end
            LOOKUP: begin
                thresh_d = prob_mem[arm_q];
                state_d  = DRAW;
            end
            DRAW: begin
                reward_d = hit ? REWARD_HIT : REWARD_MISS;
                hit_d    = hit_q + {31'd0, hit};
                lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
                state_d  = RESPOND;
            end
            RESPOND: begin
                if (reward_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            arm_q    <= 8'd0;
            thresh_q <= 16'd0;
            lfsr_q   <= SEED;
            reward_q <= 16'd0;
            pull_q   <= 32'd0;
            hit_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            arm_q    <= arm_d;
            thresh_q <= thresh_d;
            lfsr_q   <= lfsr_d;
            reward_q <= reward_d;
            pull_q   <= pull_d;
            hit_q    <= hit_d;
        end
    end

    // Ready is gated by reset so it drops the instant reset asserts.
    assign action_ready_o = rst_ni && (state_q == IDLE);
    assign reward_valid_o = (state_q == RESPOND);
    assign reward_data_o  = reward_valid_o ? reward_q : 16'h0000;
    assign pull_count_o   = pull_q;
    assign hit_count_o    = hit_q;

endmodule
